// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the sequenced ALU controller: opcodes, function fields,
// ALU control codes, cycle-count width and FSM state encoding.
package alu_ctrl_pkg;

    // Opcodes
    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_RTYPE = 6'b000010;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // R-type function fields
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_BREAK = 6'b001101;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    // ALU control codes
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_ADDU  = 4'b0100;
    localparam logic [3:0] ALU_SUBU  = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_MULT  = 4'b1000;
    localparam logic [3:0] ALU_MULTU = 4'b1001;
    localparam logic [3:0] ALU_LUI   = 4'b1010;
    localparam logic [3:0] ALU_SLTU  = 4'b1011;
    localparam logic [3:0] ALU_DIV   = 4'b1100;
    localparam logic [3:0] ALU_DIVU  = 4'b1101;
    localparam logic [3:0] ALU_BREAK = 4'b1111;

    localparam int CNT_W = 8;

    // FSM state encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_BUSY = S_BUSY,
        ST_HALT = S_HALT
    } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational op/funct decoder. Division is recognised only when
// ALU_CTRL_SEQ_DIV_EN is defined; otherwise div/divu fall through as illegal.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] code,
    output logic       is_multi,
    output logic       is_div,
    output logic       is_break,
    output logic       is_illegal
);

    always_comb begin
        code       = ALU_AND;
        is_multi   = 1'b0;
        is_div     = 1'b0;
        is_break   = 1'b0;
        is_illegal = 1'b0;
        case (op)
            OP_ADD:   code = ALU_ADD;
            OP_SUB:   code = ALU_SUB;
            OP_ORI:   code = ALU_OR;
            OP_ANDI:  code = ALU_AND;
            OP_ADDIU: code = ALU_ADDU;
            OP_SLTI:  code = ALU_SLT;
            OP_SLTIU: code = ALU_SLTU;
            OP_LUI:   code = ALU_LUI;
            OP_RTYPE: begin
                case (funct)
                    FN_AND:   code = ALU_AND;
                    FN_OR:    code = ALU_OR;
                    FN_ADD:   code = ALU_ADD;
                    FN_JR:    code = ALU_ADD;
                    FN_XOR:   code = ALU_XOR;
                    FN_ADDU:  code = ALU_ADDU;
                    FN_SUBU:  code = ALU_SUBU;
                    FN_SUB:   code = ALU_SUB;
                    FN_SLT:   code = ALU_SLT;
                    FN_SLTU:  code = ALU_SLTU;
                    FN_MULT: begin
                        code     = ALU_MULT;
                        is_multi = 1'b1;
                    end
                    FN_MULTU: begin
                        code     = ALU_MULTU;
                        is_multi = 1'b1;
                    end
`ifdef ALU_CTRL_SEQ_DIV_EN
                    FN_DIV: begin
                        code     = ALU_DIV;
                        is_multi = 1'b1;
                        is_div   = 1'b1;
                    end
                    FN_DIVU: begin
                        code     = ALU_DIVU;
                        is_multi = 1'b1;
                        is_div   = 1'b1;
                    end
`endif
                    FN_BREAK: begin
                        code     = ALU_BREAK;
                        is_break = 1'b1;
                    end
                    default: is_illegal = 1'b1;
                endcase
            end
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU controller with multi-cycle mult/div sequencing and HI/LO strobe.
// Define ALU_CTRL_SEQ_DIV_EN to enable div/divu (DIV_CYCLES latency).
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W      = 4,
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        op,
    input  logic [5:0]        funct,
    output logic [CTRL_W-1:0] control,
    output logic              busy,
    output logic              out_valid,
    output logic              hilo_we,
    output logic              illegal,
    output logic              halt
);

    if (CTRL_W < 4) begin : g_bad_ctrl_w
        $error("alu_ctrl_seq: CTRL_W must be >= 4");
    end
    if (MULT_CYCLES < 1 || MULT_CYCLES > 255) begin : g_bad_mult
        $error("alu_ctrl_seq: MULT_CYCLES out of range 1..255");
    end
    if (DIV_CYCLES < 1 || DIV_CYCLES > 255) begin : g_bad_div
        $error("alu_ctrl_seq: DIV_CYCLES out of range 1..255");
    end

    localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);

    logic [3:0] dec_code;
    logic       dec_multi;
    logic       dec_div;
    logic       dec_break;
    logic       dec_illegal;

    alu_ctrl_decode u_decode (
        .op         (op),
        .funct      (funct),
        .code       (dec_code),
        .is_multi   (dec_multi),
        .is_div     (dec_div),
        .is_break   (dec_break),
        .is_illegal (dec_illegal)
    );

    logic [CNT_W-1:0] lat;
`ifdef ALU_CTRL_SEQ_DIV_EN
    localparam logic [CNT_W-1:0] DIV_LAT = CNT_W'(DIV_CYCLES);
    assign lat = dec_div ? DIV_LAT : MULT_LAT;
`else
    logic unused_dec_div;
    assign unused_dec_div = dec_div;
    assign lat = MULT_LAT;
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CTRL_W-1:0] control_q, control_d;
    logic              busy_q, busy_d;
    logic              out_valid_q, out_valid_d;
    logic              hilo_we_q, hilo_we_d;
    logic              illegal_q, illegal_d;
    logic              halt_q, halt_d;
    logic              accept;

    // Handshake: a transfer happens on a rising edge where in_valid && in_ready;
    // in_ready depends only on state, never on in_valid. A stalled upstream
    // stage must hold op/funct stable until that edge.
    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        control_d   = control_q;
        busy_d      = busy_q;
        out_valid_d = 1'b0;
        hilo_we_d   = 1'b0;
        illegal_d   = 1'b0;
        halt_d      = halt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    control_d = CTRL_W'(dec_code);
                    if (dec_break) begin
                        out_valid_d = 1'b1;
                        halt_d      = 1'b1;
                        state_d     = ST_HALT;
                    end else if (dec_multi && lat != 8'd1) begin
                        state_d = ST_BUSY;
                        count_d = lat - 8'd1;
                        busy_d  = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        hilo_we_d   = dec_multi;
                        illegal_d   = dec_illegal;
                    end
                end
            end
            ST_BUSY: begin
                if (count_q == 8'd1) begin
                    state_d     = ST_IDLE;
                    count_d     = '0;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                    hilo_we_d   = 1'b1;
                end else begin
                    count_d = count_q - 8'd1;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            control_q   <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            hilo_we_q   <= 1'b0;
            illegal_q   <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            control_q   <= control_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            hilo_we_q   <= hilo_we_d;
            illegal_q   <= illegal_d;
            halt_q      <= halt_d;
        end
    end

    assign control   = control_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign hilo_we   = hilo_we_q;
    assign illegal   = illegal_q;
    assign halt      = halt_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: decode table, mult sequencing, illegal,
// break/halt and division (enabled or disabled by ALU_CTRL_SEQ_DIV_EN).
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] op;
  logic [5:0] funct;
  logic [3:0] control;
  logic       busy;
  logic       out_valid;
  logic       hilo_we;
  logic       illegal;
  logic       halt;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [5:0] R = 6'b000010;

  alu_ctrl_seq #(
    .CTRL_W      (4),
    .MULT_CYCLES (4),
    .DIV_CYCLES  (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .funct     (funct),
    .control   (control),
    .busy      (busy),
    .out_valid (out_valid),
    .hilo_we   (hilo_we),
    .illegal   (illegal),
    .halt      (halt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: present one instruction for one edge, then drop in_valid
  task automatic issue(input logic [5:0] o, input logic [5:0] f);
    in_valid = 1'b1;
    op       = o;
    funct    = f;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic single(input string tag, input logic [5:0] o, input logic [5:0] f,
                        input logic [3:0] exp_code, input logic exp_ill);
    issue(o, f);
    check_eq({tag, ".control"}, control, exp_code);
    check_eq({tag, ".out_valid"}, out_valid, 1'b1);
    check_eq({tag, ".illegal"}, illegal, exp_ill);
    check_eq({tag, ".hilo_we"}, hilo_we, 1'b0);
    check_eq({tag, ".in_ready"}, in_ready, 1'b1);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, ".control"}, control, 4'h0);
    check_eq({tag, ".busy"}, busy, 1'b0);
    check_eq({tag, ".out_valid"}, out_valid, 1'b0);
    check_eq({tag, ".hilo_we"}, hilo_we, 1'b0);
    check_eq({tag, ".illegal"}, illegal, 1'b0);
    check_eq({tag, ".halt"}, halt, 1'b0);
    check_eq({tag, ".in_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    op       = 6'd0;
    funct    = 6'd0;
    tick();
    tick();
    rst = 1'b0;
    check_reset_state("reset");

    // back-to-back single-cycle ops
    issue(6'b001101, 6'd0);
    check_eq("ori.control", control, 4'b0001);
    check_eq("ori.out_valid", out_valid, 1'b1);
    check_eq("ori.in_ready", in_ready, 1'b1);
    issue(6'b000000, 6'd0);
    check_eq("add.control", control, 4'b0010);
    check_eq("add.out_valid", out_valid, 1'b1);
    tick();
    check_eq("idle.out_valid_drop", out_valid, 1'b0);
    check_eq("idle.control_held", control, 4'b0010);

    // mult, latency 4, with a held ori waiting upstream
    issue(R, 6'b011000);
    in_valid = 1'b1;
    op       = 6'b001101;
    funct    = 6'd0;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) tick();
      check_eq($sformatf("mult.busy_t%0d", k), busy, 1'b1);
      check_eq($sformatf("mult.in_ready_t%0d", k), in_ready, 1'b0);
      check_eq($sformatf("mult.out_valid_t%0d", k), out_valid, 1'b0);
      check_eq($sformatf("mult.hilo_t%0d", k), hilo_we, 1'b0);
    end
    tick();
    check_eq("mult.out_valid_t4", out_valid, 1'b1);
    check_eq("mult.hilo_t4", hilo_we, 1'b1);
    check_eq("mult.control_t4", control, 4'b1000);
    check_eq("mult.busy_t4", busy, 1'b0);
    check_eq("mult.in_ready_t4", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check_eq("after_mult.control", control, 4'b0001);
    check_eq("after_mult.out_valid", out_valid, 1'b1);
    check_eq("after_mult.hilo", hilo_we, 1'b0);

    // multu
    issue(R, 6'b011001);
    tick();
    tick();
    tick();
    check_eq("multu.control", control, 4'b1001);
    check_eq("multu.hilo", hilo_we, 1'b1);

    // decode table
    single("sltu", R, 6'b101011, 4'b1011, 1'b0);
    single("sltiu", 6'b001011, 6'd0, 4'b1011, 1'b0);
    single("r_and", R, 6'b100100, 4'b0000, 1'b0);
    single("r_or", R, 6'b100101, 4'b0001, 1'b0);
    single("r_add", R, 6'b100000, 4'b0010, 1'b0);
    single("jr", R, 6'b001000, 4'b0010, 1'b0);
    single("xor", R, 6'b100110, 4'b0011, 1'b0);
    single("addu", R, 6'b100001, 4'b0100, 1'b0);
    single("subu", R, 6'b100011, 4'b0101, 1'b0);
    single("r_sub", R, 6'b100010, 4'b0110, 1'b0);
    single("slt", R, 6'b101010, 4'b0111, 1'b0);
    single("i_sub", 6'b000001, 6'd0, 4'b0110, 1'b0);
    single("andi", 6'b001100, 6'd0, 4'b0000, 1'b0);
    single("addiu", 6'b001001, 6'd0, 4'b0100, 1'b0);
    single("slti", 6'b001010, 6'd0, 4'b0111, 1'b0);
    single("lui", 6'b001111, 6'd0, 4'b1010, 1'b0);
    single("bad_funct", R, 6'b111111, 4'b0000, 1'b1);
    single("ori2", 6'b001101, 6'd0, 4'b0001, 1'b0);
    single("bad_op", 6'b111111, 6'd0, 4'b0000, 1'b1);
    tick();
    check_eq("bad_op.illegal_drop", illegal, 1'b0);
    check_eq("bad_op.out_valid_drop", out_valid, 1'b0);

`ifdef ALU_CTRL_SEQ_DIV_EN
    begin
      logic seen_hilo;
      seen_hilo = 1'b0;
      issue(R, 6'b011011);
      check_eq("divu.busy_t1", busy, 1'b1);
      check_eq("divu.control_t1", control, 4'b1101);
      for (int k = 2; k <= 10; k++) begin
        tick();
        seen_hilo = seen_hilo | hilo_we;
      end
      check_eq("divu.busy_t10", busy, 1'b1);
      rst = 1'b1;
      #1;
      check_eq("divu.async_busy", busy, 1'b0);
      check_eq("divu.async_control", control, 4'h0);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 30; k++) begin
        tick();
        seen_hilo = seen_hilo | hilo_we;
      end
      check_eq("divu.no_hilo", seen_hilo, 1'b0);
      check_reset_state("divu.after_abort");
    end
`else
    single("divu_off", R, 6'b011011, 4'b0000, 1'b1);
    check_eq("divu_off.busy", busy, 1'b0);
    single("div_off", R, 6'b011010, 4'b0000, 1'b1);
    check_eq("div_off.busy", busy, 1'b0);
`endif

    // break: sticky halt, upstream keeps offering an instruction
    issue(R, 6'b001101);
    check_eq("break.halt", halt, 1'b1);
    check_eq("break.out_valid", out_valid, 1'b1);
    check_eq("break.control", control, 4'b1111);
    check_eq("break.in_ready", in_ready, 1'b0);
    in_valid = 1'b1;
    op       = 6'b001101;
    funct    = 6'd0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check_eq($sformatf("halt.in_ready_%0d", k), in_ready, 1'b0);
      check_eq($sformatf("halt.halt_%0d", k), halt, 1'b1);
    end
    check_eq("halt.out_valid", out_valid, 1'b0);
    check_eq("halt.control_held", control, 4'b1111);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("halt.rst_clears", halt, 1'b0);
    tick();
    rst = 1'b0;
    check_reset_state("post_halt");
    single("post_halt_ori", 6'b001101, 6'd0, 4'b0001, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
